// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: SVGA 800x600 and
// VGA 640x480 timing sets, plus a ceiling-log2 helper for sizing checks.
package video_timing_pkg;

   typedef struct packed {
      logic [15:0] display;
      logic [15:0] front;
      logic [15:0] sync;
      logic [15:0] back;
   } axis_timing_t;

   // SVGA 800x600 @ 72 Hz (50 MHz pixel clock)
   localparam int SVGA_H_DISPLAY  = 800;
   localparam int SVGA_H_FRONT    = 56;
   localparam int SVGA_H_SYNC     = 120;
   localparam int SVGA_H_BACK     = 64;
   localparam int SVGA_V_DISPLAY  = 600;
   localparam int SVGA_V_FRONT    = 37;
   localparam int SVGA_V_SYNC     = 6;
   localparam int SVGA_V_BACK     = 23;
   localparam bit SVGA_H_SYNC_POL = 1'b1;
   localparam bit SVGA_V_SYNC_POL = 1'b1;

   // VGA 640x480 @ 60 Hz (25.175 MHz pixel clock)
   localparam int VGA_H_DISPLAY   = 640;
   localparam int VGA_H_FRONT     = 16;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BACK      = 48;
   localparam int VGA_V_DISPLAY   = 480;
   localparam int VGA_V_FRONT     = 10;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BACK      = 33;
   localparam bit VGA_H_SYNC_POL  = 1'b0;
   localparam bit VGA_V_SYNC_POL  = 1'b0;

   localparam axis_timing_t SVGA_H_TIMING = '{16'd800, 16'd56, 16'd120, 16'd64};
   localparam axis_timing_t SVGA_V_TIMING = '{16'd600, 16'd37, 16'd6, 16'd23};

   // Smallest w with 2**w >= n; used to confirm counter widths hold a total.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// raster_counter: x/y position pair that advances on pixel ticks, wrapping
// x at H_TOTAL-1 into the next line and both at the end of the frame.
// x_next/y_next expose the value the pair will hold after this clock so the
// parent can register decodes aligned with the counters.
module raster_counter
   import video_timing_pkg::*;
#(
   parameter int H_TOTAL = 1040,
   parameter int V_TOTAL = 666,
   parameter int X_W     = 11,
   parameter int Y_W     = 10,
   parameter int X_INIT  = 0,
   parameter int Y_INIT  = 0
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           pixel_enable,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [X_W-1:0] x_next,
   output logic [Y_W-1:0] y_next
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
   localparam logic [X_W-1:0] X_RST  = X_W'(X_INIT);
   localparam logic [Y_W-1:0] Y_RST  = Y_W'(Y_INIT);

   logic [X_W-1:0] x_r;
   logic [Y_W-1:0] y_r;

   // Next position: step x on a pixel tick, carry into y at end of line.
   always_comb begin
      x_next = x_r;
      y_next = y_r;
      if (pixel_enable) begin
         if (x_r == X_LAST) begin
            x_next = {X_W{1'b0}};
            if (y_r == Y_LAST) begin
               y_next = {Y_W{1'b0}};
            end else begin
               y_next = y_r + Y_W'(1);
            end
         end else begin
            x_next = x_r + X_W'(1);
            y_next = y_r;
         end
      end else begin
         x_next = x_r;
         y_next = y_r;
      end
   end

   // Position register; reset dominates any pixel tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_r <= X_RST;
         y_r <= Y_RST;
      end else begin
         x_r <= x_next;
         y_r <= y_next;
      end
   end

   assign x = x_r;
   assign y = y_r;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with pixel-rate
// clock enable, registered sync/blank flags and line/frame strobes.
// Optional feature macro VTG_LOOKAHEAD_EN adds a second counter pair running
// LOOKAHEAD ticks ahead (fetch_x/fetch_y/fetch_enable) to hide frame-buffer
// read latency.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_DISPLAY  = SVGA_H_DISPLAY,
   parameter int H_FRONT    = SVGA_H_FRONT,
   parameter int H_SYNC     = SVGA_H_SYNC,
   parameter int H_BACK     = SVGA_H_BACK,
   parameter int V_DISPLAY  = SVGA_V_DISPLAY,
   parameter int V_FRONT    = SVGA_V_FRONT,
   parameter int V_SYNC     = SVGA_V_SYNC,
   parameter int V_BACK     = SVGA_V_BACK,
   parameter bit H_SYNC_POL = SVGA_H_SYNC_POL,
   parameter bit V_SYNC_POL = SVGA_V_SYNC_POL,
   parameter int X_W        = 11,
   parameter int Y_W        = 10,
   parameter int LOOKAHEAD  = 2
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           pixel_enable,
   output logic [X_W-1:0] pixel_x,
   output logic [Y_W-1:0] pixel_y,
   output logic           hsync,
   output logic           vsync,
   output logic           video_enable,
   output logic           vblank,
   output logic           line_start,
   output logic           frame_start
`ifdef VTG_LOOKAHEAD_EN
   ,
   output logic [X_W-1:0] fetch_x,
   output logic [Y_W-1:0] fetch_y,
   output logic           fetch_enable
`endif
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [X_W-1:0] H_VIS_END = X_W'(H_DISPLAY);
   localparam logic [X_W-1:0] HS_START  = X_W'(H_DISPLAY + H_FRONT);
   localparam logic [X_W-1:0] HS_END    = X_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [Y_W-1:0] V_VIS_END = Y_W'(V_DISPLAY);
   localparam logic [Y_W-1:0] VS_START  = Y_W'(V_DISPLAY + V_FRONT);
   localparam logic [Y_W-1:0] VS_END    = Y_W'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [X_W-1:0] x_next_s;
   logic [Y_W-1:0] y_next_s;
   logic           hsync_next_s;
   logic           vsync_next_s;
   logic           video_enable_next_s;
   logic           vblank_next_s;
   logic           hsync_r;
   logic           vsync_r;
   logic           video_enable_r;
   logic           vblank_r;

   raster_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .X_W     (X_W),
      .Y_W     (Y_W),
      .X_INIT  (0),
      .Y_INIT  (0)
   ) u_pixel_counter (
      .clock        (clock),
      .reset        (reset),
      .pixel_enable (pixel_enable),
      .x            (pixel_x),
      .y            (pixel_y),
      .x_next       (x_next_s),
      .y_next       (y_next_s)
   );

   // Decode flags from the upcoming position so the registers line up with it.
   always_comb begin
      hsync_next_s        = ~H_SYNC_POL;
      vsync_next_s        = ~V_SYNC_POL;
      video_enable_next_s = 1'b0;
      vblank_next_s       = 1'b0;
      if ((x_next_s >= HS_START) && (x_next_s < HS_END)) begin
         hsync_next_s = H_SYNC_POL;
      end else begin
         hsync_next_s = ~H_SYNC_POL;
      end
      if ((y_next_s >= VS_START) && (y_next_s < VS_END)) begin
         vsync_next_s = V_SYNC_POL;
      end else begin
         vsync_next_s = ~V_SYNC_POL;
      end
      if ((x_next_s < H_VIS_END) && (y_next_s < V_VIS_END)) begin
         video_enable_next_s = 1'b1;
      end else begin
         video_enable_next_s = 1'b0;
      end
      if (y_next_s >= V_VIS_END) begin
         vblank_next_s = 1'b1;
      end else begin
         vblank_next_s = 1'b0;
      end
   end

   // Glitch-free registered sync and blanking outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         hsync_r        <= ~H_SYNC_POL;
         vsync_r        <= ~V_SYNC_POL;
         video_enable_r <= 1'b1;
         vblank_r       <= 1'b0;
      end else begin
         hsync_r        <= hsync_next_s;
         vsync_r        <= vsync_next_s;
         video_enable_r <= video_enable_next_s;
         vblank_r       <= vblank_next_s;
      end
   end

   assign hsync        = hsync_r;
   assign vsync        = vsync_r;
   assign video_enable = video_enable_r;
   assign vblank       = vblank_r;

   // Strobes qualify the current position with the tick and stay quiet in reset.
   assign line_start  = pixel_enable & ~reset & (pixel_x == {X_W{1'b0}});
   assign frame_start = line_start & (pixel_y == {Y_W{1'b0}});

`ifdef VTG_LOOKAHEAD_EN
   localparam bit FETCH_EN_RST = (LOOKAHEAD < H_DISPLAY);

   logic [X_W-1:0] fetch_x_next_s;
   logic [Y_W-1:0] fetch_y_next_s;
   logic           fetch_enable_next_s;
   logic           fetch_enable_r;

   raster_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .X_W     (X_W),
      .Y_W     (Y_W),
      .X_INIT  (LOOKAHEAD),
      .Y_INIT  (0)
   ) u_fetch_counter (
      .clock        (clock),
      .reset        (reset),
      .pixel_enable (pixel_enable),
      .x            (fetch_x),
      .y            (fetch_y),
      .x_next       (fetch_x_next_s),
      .y_next       (fetch_y_next_s)
   );

   // Visible-area decode at the look-ahead position.
   always_comb begin
      fetch_enable_next_s = 1'b0;
      if ((fetch_x_next_s < H_VIS_END) && (fetch_y_next_s < V_VIS_END)) begin
         fetch_enable_next_s = 1'b1;
      end else begin
         fetch_enable_next_s = 1'b0;
      end
   end

   // Registered fetch enable, aligned with fetch_x/fetch_y.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_enable_r <= FETCH_EN_RST;
      end else begin
         fetch_enable_r <= fetch_enable_next_s;
      end
   end

   assign fetch_enable = fetch_enable_r;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: three instances (SVGA defaults, a
// tiny 8x6 raster, and an 8-pixel line with the SVGA vertical timing) share
// stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_video_timing_gen;

   localparam int P_HD [3] = '{800, 4, 4};
   localparam int P_HF [3] = '{56, 1, 1};
   localparam int P_HS [3] = '{120, 2, 2};
   localparam int P_HB [3] = '{64, 1, 1};
   localparam int P_VD [3] = '{600, 3, 600};
   localparam int P_VF [3] = '{37, 1, 37};
   localparam int P_VS [3] = '{6, 1, 6};
   localparam int P_VB [3] = '{23, 1, 23};
   localparam bit P_HP [3] = '{1'b1, 1'b0, 1'b0};
   localparam bit P_VP [3] = '{1'b1, 1'b0, 1'b1};
   localparam int LA = 2;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        hs, vs, ve, vb, ls, fs;
`ifdef VTG_LOOKAHEAD_EN
      logic [10:0] fx;
      logic [9:0]  fy;
      logic        fe;
`endif
   } obs_t;
   typedef obs_t [2:0] trio_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic pixel_enable = 1'b1;

   logic [10:0] px [3];
   logic [9:0]  py [3];
   logic        hs [3], vs [3], ve [3], vb [3], ls [3], fs [3];
`ifdef VTG_LOOKAHEAD_EN
   logic [10:0] fx [3];
   logic [9:0]  fy [3];
   logic        fe [3];
`endif

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      video_timing_gen #(
         .H_DISPLAY(P_HD[g]), .H_FRONT(P_HF[g]), .H_SYNC(P_HS[g]), .H_BACK(P_HB[g]),
         .V_DISPLAY(P_VD[g]), .V_FRONT(P_VF[g]), .V_SYNC(P_VS[g]), .V_BACK(P_VB[g]),
         .H_SYNC_POL(P_HP[g]), .V_SYNC_POL(P_VP[g]),
         .X_W(11), .Y_W(10), .LOOKAHEAD(LA)
      ) u_dut (
         .clock        (clock),
         .reset        (reset),
         .pixel_enable (pixel_enable),
         .pixel_x      (px[g]),
         .pixel_y      (py[g]),
         .hsync        (hs[g]),
         .vsync        (vs[g]),
         .video_enable (ve[g]),
         .vblank       (vb[g]),
         .line_start   (ls[g]),
         .frame_start  (fs[g])
`ifdef VTG_LOOKAHEAD_EN
         ,
         .fetch_x      (fx[g]),
         .fetch_y      (fy[g]),
         .fetch_enable (fe[g])
`endif
      );
   end

   int tests = 0;
   int fails = 0;
   trio_t exp_q [$];

   // reference positions
   int mx [3], my [3], mfx [3], mfy [3];

   // hand-checked observations
   int cyc = 0;
   int a_hs_cnt = 0, a_hs_first = -1, a_hs_last = -1, a_ve_fall = -1;
   int b_fs_t [$];
   int b_hs_lo_cnt = 0, b_hs_lo_first = -1, b_vs_lo_cnt = 0, b_vs_lo_y = -1;
   int c_fs_t [$];
   int c_vs_cnt = 0, c_vs_min = 9999, c_vs_max = -1;

   function automatic int htot(int d);
      return P_HD[d] + P_HF[d] + P_HS[d] + P_HB[d];
   endfunction

   function automatic int vtot(int d);
      return P_VD[d] + P_VF[d] + P_VS[d] + P_VB[d];
   endfunction

   function automatic obs_t model(int d, int x, int y, int fxv, int fyv, bit pe, bit rst);
      obs_t o;
      int hs0, vs0;
      hs0 = P_HD[d] + P_HF[d];
      vs0 = P_VD[d] + P_VF[d];
      o = '0;
      o.x  = 11'(x);
      o.y  = 10'(y);
      o.hs = (x >= hs0 && x < hs0 + P_HS[d]) ? P_HP[d] : !P_HP[d];
      o.vs = (y >= vs0 && y < vs0 + P_VS[d]) ? P_VP[d] : !P_VP[d];
      o.ve = (x < P_HD[d]) && (y < P_VD[d]);
      o.vb = (y >= P_VD[d]);
      o.ls = pe && !rst && (x == 0);
      o.fs = pe && !rst && (x == 0) && (y == 0);
`ifdef VTG_LOOKAHEAD_EN
      o.fx = 11'(fxv);
      o.fy = 10'(fyv);
      o.fe = (fxv < P_HD[d]) && (fyv < P_VD[d]);
`else
      if (fxv < 0 || fyv < 0) o.x = 11'(x);
`endif
      return o;
   endfunction

   function automatic obs_t actual(int d);
      obs_t o;
      o = '0;
      o.x = px[d]; o.y = py[d];
      o.hs = hs[d]; o.vs = vs[d]; o.ve = ve[d]; o.vb = vb[d]; o.ls = ls[d]; o.fs = fs[d];
`ifdef VTG_LOOKAHEAD_EN
      o.fx = fx[d]; o.fy = fy[d]; o.fe = fe[d];
`endif
      return o;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         mx[d] = 0; my[d] = 0; mfx[d] = LA; mfy[d] = 0;
      end
   endtask

   task automatic model_tick(int d);
      if (mx[d] == htot(d) - 1) begin
         mx[d] = 0;
         my[d] = (my[d] == vtot(d) - 1) ? 0 : my[d] + 1;
      end else begin
         mx[d] = mx[d] + 1;
      end
      if (mfx[d] == htot(d) - 1) begin
         mfx[d] = 0;
         mfy[d] = (mfy[d] == vtot(d) - 1) ? 0 : mfy[d] + 1;
      end else begin
         mfx[d] = mfx[d] + 1;
      end
   endtask

   // one clock of stimulus: drive, queue expectation, let the edge happen, advance model
   task automatic step(bit pe, bit rst);
      trio_t e;
      pixel_enable = pe;
      reset = rst;
      for (int d = 0; d < 3; d++) e[d] = model(d, mx[d], my[d], mfx[d], mfy[d], pe, rst);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      if (rst) model_reset();
      else if (pe) for (int d = 0; d < 3; d++) model_tick(d);
   endtask

   task automatic chk(string name, int act, int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual %0d, required %0d", name, act, req);
      end
   endtask

   // monitor: pop one expectation per presented output cycle and compare
   always @(negedge clock) begin : monitor
      trio_t e;
      obs_t a;
      obs_t r0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int d = 0; d < 3; d++) begin
            a = actual(d);
            tests++;
            if (a !== e[d]) begin
               fails++;
               $display("FAIL dut%0d cycle %0d: actual x=%0d y=%0d raw=%h, required x=%0d y=%0d raw=%h",
                        d, cyc, a.x, a.y, a, e[d].x, e[d].y, e[d]);
            end
            if (d == 0 && cyc < 1040) begin
               if (a.hs) begin
                  a_hs_cnt++;
                  if (a_hs_first < 0) a_hs_first = int'(a.x);
                  a_hs_last = int'(a.x);
               end
               if (!a.ve && a_ve_fall < 0) a_ve_fall = int'(a.x);
            end
            if (d == 1 && cyc < 5400) begin
               if (a.fs) b_fs_t.push_back(cyc);
               if (cyc < 8 && !a.hs) begin
                  b_hs_lo_cnt++;
                  if (b_hs_lo_first < 0) b_hs_lo_first = int'(a.x);
               end
               if (cyc < 48 && !a.vs) begin
                  b_vs_lo_cnt++;
                  if (b_vs_lo_y < 0) b_vs_lo_y = int'(a.y);
               end
            end
            if (d == 2 && cyc < 5400) begin
               if (a.fs) c_fs_t.push_back(cyc);
               if (a.vs) begin
                  c_vs_cnt++;
                  if (int'(a.y) < c_vs_min) c_vs_min = int'(a.y);
                  if (int'(a.y) > c_vs_max) c_vs_max = int'(a.y);
               end
            end
`ifdef VTG_LOOKAHEAD_EN
            if (d == 0 && a.x == 11'd1038 && a.y == 10'd0) begin
               tests++;
               if (a.fx != 11'd0 || a.fy != 10'd1) begin
                  fails++;
                  $display("FAIL fetch_line_wrap: actual (%0d,%0d), required (0,1)", a.fx, a.fy);
               end
            end
            if (d == 2 && a.x == 11'd6 && a.y == 10'd665) begin
               tests++;
               if (a.fx != 11'd0 || a.fy != 10'd0) begin
                  fails++;
                  $display("FAIL fetch_frame_wrap: actual (%0d,%0d), required (0,0)", a.fx, a.fy);
               end
            end
`endif
            if (d == 0 && cyc == 0) begin
               r0 = a;
               tests++;
               if (r0.x != 11'd0 || r0.y != 10'd0 || r0.hs != 1'b0 || r0.vs != 1'b0 ||
                   r0.ve != 1'b1 || r0.vb != 1'b0 || r0.fs != 1'b1 || r0.ls != 1'b1) begin
                  fails++;
                  $display("FAIL reset_state: actual x=%0d y=%0d hs=%b vs=%b ve=%b vb=%b ls=%b fs=%b, required 0 0 0 0 1 0 1 1",
                           r0.x, r0.y, r0.hs, r0.vs, r0.ve, r0.vb, r0.ls, r0.fs);
               end
            end
         end
         cyc++;
      end
   end

   initial begin
      reset = 1'b1;
      pixel_enable = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      model_reset();
      // free-running: covers a full line of the SVGA instance and full frames of the others
      for (int i = 0; i < 5400; i++) step(1'b1, 1'b0);
      // alternating pixel ticks
      for (int i = 0; i < 40; i++) step((i % 2) == 0, 1'b0);
      // mid-frame reset with pixel_enable still high
      step(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      @(negedge clock);
      #1;

      chk("queue_drained", exp_q.size(), 0);
      chk("svga_hsync_width", a_hs_cnt, 120);
      chk("svga_hsync_first_x", a_hs_first, 856);
      chk("svga_hsync_last_x", a_hs_last, 975);
      chk("svga_video_enable_fall_x", a_ve_fall, 800);
      chk("tiny_frame_period", (b_fs_t.size() >= 2) ? b_fs_t[1] - b_fs_t[0] : -1, 48);
      chk("tiny_hsync_low_count", b_hs_lo_cnt, 2);
      chk("tiny_hsync_low_first_x", b_hs_lo_first, 5);
      chk("tiny_vsync_low_count", b_vs_lo_cnt, 8);
      chk("tiny_vsync_low_line", b_vs_lo_y, 4);
      chk("narrow_frame_period", (c_fs_t.size() >= 2) ? c_fs_t[1] - c_fs_t[0] : -1, 5328);
      chk("narrow_vsync_cycles", c_vs_cnt, 48);
      chk("narrow_vsync_first_line", c_vs_min, 637);
      chk("narrow_vsync_last_line", c_vs_max, 642);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
